alu_seq: RTL and testbench

Parametrised, registered successor to the datapath's 8-bit combinational ALU. It accepts one operation per valid/ready handshake and registers the result together with zero, carry and overflow flags. Logical shifts can run iteratively, one bit per cycle, which trades latency for area. It sits between the register file read stage and writeback, and its handshakes let it stall the pipeline.

---
 rtl/alu_seq_if.sv | 20 ++
 rtl/alu_seq.sv | 109 ++++++++++
 tb/tb_alu_seq.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_if.sv
// alu_seq_if: operation/result handshake bundle for alu_seq
//   in_valid/in_ready       : operation handshake (producer -> ALU)
//   alu_input_a/b, opcode   : operands and operation code
//   out_valid/out_ready     : result handshake (ALU -> consumer)
//   alu_out, zero/carry/ovf : registered result and flags
//   busy                    : iterative shift in progress
interface alu_seq_if #(parameter int WIDTH = 8);
   logic             in_valid, in_ready, out_valid, out_ready;
   logic             zero, carry, overflow, busy;
   logic [WIDTH-1:0] alu_input_a, alu_input_b, alu_out;
   logic [2:0]       alu_opcode;
   modport master (
      output in_valid, alu_input_a, alu_input_b, alu_opcode, out_ready,
      input  in_ready, out_valid, alu_out, zero, carry, overflow, busy
   );
   modport slave (
      input  in_valid, alu_input_a, alu_input_b, alu_opcode, out_ready,
      output in_ready, out_valid, alu_out, zero, carry, overflow, busy
   );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with valid/ready handshakes and optional iterative shifter
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : alu_seq_if slave port carrying operands, opcode, result, flags, busy
module alu_seq #(
   parameter int WIDTH      = 8,
   parameter bit FAST_SHIFT = 1'b0
) (
   input logic      clk,
   input logic      reset,
   alu_seq_if.slave bus
);
   localparam int CW = $clog2(WIDTH + 1);
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
   state_t           state_q, state_d;
   logic [WIDTH-1:0] res_q, res_d, work_q, work_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             carry_q, carry_d, ovf_q, ovf_d, dir_q, dir_d;
   logic [WIDTH-1:0] a, b, alu_r, work_nx;
   logic [WIDTH:0]   sum;
   logic [CW-1:0]    k;
   logic [2:0]       op;
   logic             accept, ovf, is_shift, flag_en;
   assign a        = bus.alu_input_a;
   assign b        = bus.alu_input_b;
   assign op       = bus.alu_opcode;
   assign sum      = {1'b0, a} + {1'b0, b};
   assign ovf      = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
   // Shift amounts of WIDTH or more saturate at WIDTH, which shifts everything out
   assign k        = (b >= WIDTH'(WIDTH)) ? CW'(WIDTH) : b[CW-1:0];
   assign is_shift = op[2] & ~op[1];
   assign flag_en  = (op == 3'b001) || (op == 3'b111);
   assign accept   = bus.in_valid && bus.in_ready;
   assign work_nx  = dir_q ? work_q >> 1 : work_q << 1;
   always_comb begin
      alu_r = '0;
      case (op)
         3'b000: alu_r = a & b;
         3'b001: alu_r = sum[WIDTH-1:0];
         3'b010: alu_r = a ^ b;
         3'b011: alu_r = {{(WIDTH-1){1'b0}}, a < b};
         3'b100: alu_r = a << k;
         3'b101: alu_r = a >> k;
         3'b110: alu_r = {{(WIDTH-1){1'b0}}, a != b};
         3'b111: alu_r = {{(WIDTH-1){1'b0}}, ovf};
      endcase
   end
   always_comb begin
      state_d = state_q;
      res_d   = res_q;
      carry_d = carry_q;
      ovf_d   = ovf_q;
      work_d  = work_q;
      cnt_d   = cnt_q;
      dir_d   = dir_q;
      if (state_q == SHIFT) begin
         work_d = work_nx;
         cnt_d  = cnt_q - CW'(1);
         if (cnt_q == CW'(1)) begin
            res_d   = work_nx;
            carry_d = 1'b0;
            ovf_d   = 1'b0;
            state_d = DONE;
         end
      end else if (accept) begin
         // Accept is possible from IDLE or from DONE while the result is consumed
         if (is_shift && !FAST_SHIFT && k != '0) begin
            work_d  = a;
            cnt_d   = k;
            dir_d   = op[0];
            state_d = SHIFT;
         end else begin
            res_d   = alu_r;
            carry_d = flag_en & sum[WIDTH];
            ovf_d   = flag_en & ovf;
            state_d = DONE;
         end
      end else if (state_q == DONE && bus.out_ready) begin
         state_d = IDLE;
      end
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         res_q   <= '0;
         work_q  <= '0;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         ovf_q   <= 1'b0;
         dir_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         res_q   <= res_d;
         work_q  <= work_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         ovf_q   <= ovf_d;
         dir_q   <= dir_d;
      end
   end
   assign bus.in_ready  = (state_q == IDLE) || (state_q == DONE && bus.out_ready);
   assign bus.out_valid = (state_q == DONE);
   assign bus.busy      = (state_q == SHIFT);
   assign bus.alu_out   = res_q;
   // zero is qualified by out_valid so it reads 0 out of reset
   assign bus.zero      = (state_q == DONE) && (res_q == '0);
   assign bus.carry     = carry_q;
   assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: self-checking bench for alu_seq (8-bit iterative and 16-bit barrel instances)
module tb_alu_seq;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   alu_seq_if #(.WIDTH(8))  b8 ();
   alu_seq_if #(.WIDTH(16)) b16 ();
   alu_seq #(.WIDTH(8),  .FAST_SHIFT(1'b0)) dut8  (.clk(clk), .reset(reset), .bus(b8));
   alu_seq #(.WIDTH(16), .FAST_SHIFT(1'b1)) dut16 (.clk(clk), .reset(reset), .bus(b16));

   logic        iv[2], ordy[2];
   logic [2:0]  op_in[2];
   logic [15:0] a_in[2], b_in[2];
   logic        rdy_o[2], ov_o[2], busy_o[2], z_o[2], c_o[2], v_o[2];
   logic [15:0] res_o[2];

   assign b8.in_valid     = iv[0];
   assign b8.out_ready    = ordy[0];
   assign b8.alu_opcode   = op_in[0];
   assign b8.alu_input_a  = a_in[0][7:0];
   assign b8.alu_input_b  = b_in[0][7:0];
   assign b16.in_valid    = iv[1];
   assign b16.out_ready   = ordy[1];
   assign b16.alu_opcode  = op_in[1];
   assign b16.alu_input_a = a_in[1];
   assign b16.alu_input_b = b_in[1];
   assign rdy_o[0]  = b8.in_ready;
   assign ov_o[0]   = b8.out_valid;
   assign busy_o[0] = b8.busy;
   assign z_o[0]    = b8.zero;
   assign c_o[0]    = b8.carry;
   assign v_o[0]    = b8.overflow;
   assign res_o[0]  = {8'h00, b8.alu_out};
   assign rdy_o[1]  = b16.in_ready;
   assign ov_o[1]   = b16.out_valid;
   assign busy_o[1] = b16.busy;
   assign z_o[1]    = b16.zero;
   assign c_o[1]    = b16.carry;
   assign v_o[1]    = b16.overflow;
   assign res_o[1]  = b16.alu_out;

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(string nm, logic [15:0] act, logic [15:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: per-instance width, shifter style, pending-shift cycles and held result
   int          W[2] = '{8, 16};
   bit          F[2] = '{1'b0, 1'b1};
   int          pend[2];
   bit          have[2];
   logic [15:0] m_res[2];
   logic        m_c[2], m_v[2];

   function automatic int kamt(int w, logic [15:0] b);
      int bb = int'(b & 16'((32'd1 << w) - 1));
      return (bb >= w) ? w : bb;
   endfunction

   function automatic void calc(int w, logic [15:0] a, logic [15:0] b, logic [2:0] op,
                                output logic [15:0] r, output logic c, output logic v);
      logic [15:0] m = 16'((32'd1 << w) - 1);
      int s, k;
      a = a & m;
      b = b & m;
      s = int'(a) + int'(b);
      c = s[w];
      v = (a[w-1] == b[w-1]) && (s[w-1] != a[w-1]);
      k = kamt(w, b);
      case (op)
         3'd0: r = a & b;
         3'd1: r = 16'(s) & m;
         3'd2: r = a ^ b;
         3'd3: r = {15'd0, a < b};
         3'd4: r = 16'(32'(a) << k) & m;
         3'd5: r = a >> k;
         3'd6: r = {15'd0, a != b};
         default: r = {15'd0, v};
      endcase
      if (op != 3'd1 && op != 3'd7) begin
         c = 1'b0;
         v = 1'b0;
      end
   endfunction

   initial begin
      pend = '{0, 0};
      have = '{1'b0, 1'b0};
      forever begin
         @(posedge clk or posedge reset);
         for (int d = 0; d < 2; d++) begin
            if (reset) begin
               pend[d] = 0;
               have[d] = 1'b0;
            end else if (pend[d] > 0) begin
               pend[d]--;
               if (pend[d] == 0) have[d] = 1'b1;
            end else begin
               bit acc;
               acc = iv[d] && (!have[d] || ordy[d]);
               if (have[d] && ordy[d]) have[d] = 1'b0;
               if (acc) begin
                  calc(W[d], a_in[d], b_in[d], op_in[d], m_res[d], m_c[d], m_v[d]);
                  if (op_in[d][2:1] == 2'b10 && !F[d] && kamt(W[d], b_in[d]) > 0)
                     pend[d] = kamt(W[d], b_in[d]);
                  else
                     have[d] = 1'b1;
               end
            end
         end
      end
   end

   initial forever begin
      @(posedge clk);
      #2;
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("in_ready[%0d]", d), 16'(rdy_o[d]), 16'(pend[d] == 0 && (!have[d] || ordy[d])));
         chk($sformatf("out_valid[%0d]", d), 16'(ov_o[d]), 16'(have[d]));
         chk($sformatf("busy[%0d]", d), 16'(busy_o[d]), 16'(pend[d] > 0));
         if (have[d]) begin
            chk($sformatf("alu_out[%0d]", d), res_o[d], m_res[d]);
            chk($sformatf("carry[%0d]", d), 16'(c_o[d]), 16'(m_c[d]));
            chk($sformatf("overflow[%0d]", d), 16'(v_o[d]), 16'(m_v[d]));
            chk($sformatf("zero[%0d]", d), 16'(z_o[d]), 16'(m_res[d] == 16'h0));
         end
      end
   end

   task automatic issue(int d, logic [2:0] o, logic [15:0] a, logic [15:0] b);
      bit acc = 1'b0;
      iv[d] = 1'b1;
      op_in[d] = o;
      a_in[d] = a;
      b_in[d] = b;
      for (int i = 0; i < 50 && !acc; i++) begin
         #1;
         acc = rdy_o[d];
         @(negedge clk);
      end
      iv[d] = 1'b0;
      if (!acc) chk("accept_timeout", 16'd0, 16'd1);
   endtask

   task automatic op_chk(int d, logic [2:0] o, logic [15:0] a, logic [15:0] b,
                         logic [15:0] r, logic c, logic v, int lat);
      int n = 1;
      ordy[d] = 1'b1;
      issue(d, o, a, b);
      while (!ov_o[d] && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk($sformatf("latency op%0d", o), 16'(n), 16'(lat));
      chk($sformatf("lit_result op%0d", o), res_o[d], r);
      chk($sformatf("lit_carry op%0d", o), 16'(c_o[d]), 16'(c));
      chk($sformatf("lit_overflow op%0d", o), 16'(v_o[d]), 16'(v));
      chk($sformatf("lit_zero op%0d", o), 16'(z_o[d]), 16'(r == 16'h0));
   endtask

   initial begin
      reset = 1'b1;
      iv = '{1'b0, 1'b0};
      ordy = '{1'b1, 1'b1};
      op_in = '{3'd0, 3'd0};
      a_in = '{16'h0, 16'h0};
      b_in = '{16'h0, 16'h0};
      #1;
      chk("reset_out_valid", 16'(ov_o[0]), 16'd0);
      chk("reset_alu_out", res_o[0], 16'h0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      #1;
      chk("reset_in_ready", 16'(rdy_o[0]), 16'd1);
      chk("reset_zero", 16'(z_o[0]), 16'd0);
      @(negedge clk);
      op_chk(0, 3'b001, 16'hF0, 16'h20, 16'h10, 1'b1, 1'b0, 1);
      op_chk(0, 3'b111, 16'h7F, 16'h01, 16'h01, 1'b0, 1'b1, 1);
      op_chk(0, 3'b111, 16'h80, 16'h80, 16'h01, 1'b1, 1'b1, 1);
      op_chk(0, 3'b111, 16'h01, 16'h01, 16'h00, 1'b0, 1'b0, 1);
      op_chk(0, 3'b100, 16'h81, 16'h03, 16'h08, 1'b0, 1'b0, 4);
      op_chk(0, 3'b101, 16'hFF, 16'h09, 16'h00, 1'b0, 1'b0, 9);
      // Backpressure, then same-edge consume-and-accept
      repeat (2) @(negedge clk);
      ordy[0] = 1'b0;
      issue(0, 3'b010, 16'h5A, 16'hFF);
      iv[0] = 1'b1;
      op_in[0] = 3'b000;
      a_in[0] = 16'h0F;
      b_in[0] = 16'h3C;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("bp_in_ready", 16'(rdy_o[0]), 16'd0);
         chk("bp_out_valid", 16'(ov_o[0]), 16'd1);
         chk("bp_alu_out", res_o[0], 16'hA5);
         @(negedge clk);
      end
      ordy[0] = 1'b1;
      #1;
      chk("handoff_in_ready", 16'(rdy_o[0]), 16'd1);
      @(negedge clk);
      iv[0] = 1'b0;
      chk("handoff_out_valid", 16'(ov_o[0]), 16'd1);
      chk("handoff_alu_out", res_o[0], 16'h0C);
      // Asynchronous reset in the middle of an iterative shift
      issue(0, 3'b100, 16'h01, 16'h05);
      @(negedge clk);
      chk("mid_shift_busy", 16'(busy_o[0]), 16'd1);
      #2;
      reset = 1'b1;
      #1;
      chk("async_out_valid", 16'(ov_o[0]), 16'd0);
      chk("async_busy", 16'(busy_o[0]), 16'd0);
      chk("async_alu_out", res_o[0], 16'h0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("post_reset_in_ready", 16'(rdy_o[0]), 16'd1);
      op_chk(0, 3'b001, 16'h01, 16'h01, 16'h02, 1'b0, 1'b0, 1);
      // 16-bit barrel-shift instance
      op_chk(1, 3'b101, 16'h8000, 16'd15, 16'h0001, 1'b0, 1'b0, 1);
      op_chk(1, 3'b011, 16'h0001, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1);
      op_chk(1, 3'b110, 16'h1234, 16'h1234, 16'h0000, 1'b0, 1'b0, 1);
      op_chk(1, 3'b100, 16'hFFFF, 16'd16, 16'h0000, 1'b0, 1'b0, 1);
      // Randomized traffic on both instances
      for (int c = 0; c < 1500; c++) begin
         @(negedge clk);
         for (int d = 0; d < 2; d++) begin
            iv[d] = ($urandom_range(0, 9) < 7);
            ordy[d] = ($urandom_range(0, 9) < 7);
            op_in[d] = 3'($urandom);
            a_in[d] = 16'($urandom);
            b_in[d] = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 18)) : 16'($urandom);
         end
      end
      @(negedge clk);
      iv = '{1'b0, 1'b0};
      ordy = '{1'b1, 1'b1};
      repeat (20) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
